// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, ID/EX bundle layout and operand-use helpers.
package decode_stage_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int OPC_W    = 7;
  localparam int F3_W     = 3;
  localparam int F7_W     = 7;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic              writes_rd;
  } idex_t;

  // Only the upper-immediate and JAL forms ignore rs1.
  function automatic logic f_uses_rs1(input logic [OPC_W-1:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic f_uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  // Opcode-level answer; the caller still masks rd==0.
  function automatic logic f_writes_rd(input logic [OPC_W-1:0] opc);
    return !(opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate format from the opcode.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o
);

  // Unknown opcodes fall back to the I-type layout
  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_OP:     imm_o = '0;
      OPC_STORE:  imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_LUI,
      OPC_AUIPC:  imm_o = {instr_i[31:12], 12'b0};
      OPC_JAL:    imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
      default:    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: holds one instruction, reads operands, stalls on RAW hazards via a
// busy-bit scoreboard and issues through a valid/ready ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              wb_write,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   data,
  output logic              should_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [F3_W-1:0]   out_funct3,
  output logic [F7_W-1:0]   out_funct7,
  output logic              out_writes_rd
);

  logic                id_valid_q, id_valid_d;
  logic [XLEN-1:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0]     id_pc_q, id_pc_d;
  logic                out_valid_q, out_valid_d;
  idex_t               out_q, out_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [OPC_W-1:0]    dec_opcode;
  logic [REG_AW-1:0]   dec_rd, dec_rs1, dec_rs2;
  logic                dec_writes_rd;
  logic [XLEN-1:0]     dec_imm;
  logic                hazard, issue, accept;

  assign dec_opcode    = id_instr_q[6:0];
  assign dec_rd        = id_instr_q[11:7];
  assign dec_rs1       = id_instr_q[19:15];
  assign dec_rs2       = id_instr_q[24:20];
  assign dec_writes_rd = f_writes_rd(dec_opcode) && (dec_rd != '0);

  decode_stage_imm_gen u_imm_gen (
    .instr_i (id_instr_q),
    .imm_o   (dec_imm)
  );

  // Register file ports: read addresses from the held instruction, write port straight from writeback
  assign rs1          = dec_rs1;
  assign rs2          = dec_rs2;
  assign rd           = wb_rd;
  assign data         = wb_data;
  assign should_write = wb_write;

  // The scoreboard is not bypassed: a writeback landing this cycle still stalls the consumer
  assign hazard = (f_uses_rs1(dec_opcode) && (dec_rs1 != '0) && busy_q[dec_rs1]) ||
                  (f_uses_rs2(dec_opcode) && (dec_rs2 != '0) && busy_q[dec_rs2]);
  assign issue    = id_valid_q && !hazard && (!out_valid_q || out_ready) && !flush;
  assign in_ready = !flush && (!id_valid_q || issue);
  assign accept   = in_valid && in_ready;

  // Next-state for ID slot, ID/EX register and scoreboard; issue-set beats writeback-clear
  always_comb begin
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    busy_d      = busy_q;
    if (flush) begin
      id_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = '0;
    end else begin
      if (wb_write && (wb_rd != '0)) busy_d[wb_rd] = 1'b0;
      if (issue) begin
        out_valid_d     = 1'b1;
        out_d.pc        = id_pc_q;
        out_d.op1       = rs1_data;
        out_d.op2       = rs2_data;
        out_d.imm       = dec_imm;
        out_d.rd        = dec_rd;
        out_d.opcode    = dec_opcode;
        out_d.funct3    = id_instr_q[14:12];
        out_d.funct7    = id_instr_q[31:25];
        out_d.writes_rd = dec_writes_rd;
        if (dec_writes_rd) busy_d[dec_rd] = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        id_valid_d = 1'b1;
        id_instr_d = in_instr;
        id_pc_d    = in_pc;
      end else if (issue) begin
        id_valid_d = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_valid_q  <= 1'b0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_op1       = out_q.op1;
  assign out_op2       = out_q.op2;
  assign out_imm       = out_q.imm;
  assign out_rd        = out_q.rd;
  assign out_opcode    = out_q.opcode;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_writes_rd = out_q.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage with a register-file model, directed scenarios and random traffic.
module tb_decode_stage;

  localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_LD = 7'h03, T_ST = 7'h23;
  localparam logic [6:0] T_BR = 7'h63, T_JAL = 7'h6F, T_JALR = 7'h67, T_LUI = 7'h37;
  localparam logic [6:0] T_AUI = 7'h17;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_write = 1'b0;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        should_write;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic        out_writes_rd;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_write(wb_write), .rd(rd), .data(data), .should_write(should_write),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_writes_rd(out_writes_rd)
  );

  // Register file: combinational read, write at the clock edge, x0 hard-wired to zero
  logic [31:0] regs [32];
  assign rs1_data = regs[rs1];
  assign rs2_data = regs[rs2];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i * 17);
    end else if (should_write && rd != 5'd0) begin
      regs[rd] <= data;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one held instruction, an issued bundle and a set of pending destinations
  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        wr;
  } bundle_t;

  logic        m_id_v = 1'b0, m_out_v = 1'b0;
  logic [31:0] m_id_ins = '0, m_id_pc = '0;
  bit          m_busy [32];
  bundle_t     m_b;

  function automatic logic [31:0] f_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      T_OP:         v = 0;
      T_ST:         v = int'($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
      T_BR:         v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                        int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      T_LUI, T_AUI: v = int'(ins & 32'hFFFF_F000);
      T_JAL:        v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 +
                        int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default:      v = int'($signed(ins) >>> 20);
    endcase
    return 32'(v);
  endfunction

  function automatic logic f_r1(input logic [6:0] op);
    return !(op == T_LUI || op == T_AUI || op == T_JAL);
  endfunction

  function automatic logic f_r2(input logic [6:0] op);
    return op == T_OP || op == T_ST || op == T_BR;
  endfunction

  // One clock: compare at the falling edge, then advance the model at the rising edge
  task automatic step();
    logic [6:0] op;
    logic [4:0] r1, r2, rdx;
    logic       wr, haz, iss, rdy;
    logic       n_id_v, n_out_v;
    logic [31:0] n_ins, n_pc;
    bit         n_busy [32];
    bundle_t    nb;
    @(negedge clock);
    op  = m_id_ins[6:0];
    rdx = m_id_ins[11:7];
    r1  = m_id_ins[19:15];
    r2  = m_id_ins[24:20];
    wr  = !(op == T_ST || op == T_BR) && rdx != 0;
    haz = (f_r1(op) && r1 != 0 && m_busy[r1]) || (f_r2(op) && r2 != 0 && m_busy[r2]);
    iss = m_id_v && !haz && (!m_out_v || out_ready) && !flush;
    rdy = !flush && (!m_id_v || iss);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_out_v);
    chk("wb_pass", {rd, should_write}, {wb_rd, wb_write});
    chk("wb_data_pass", data, wb_data);
    if (m_id_v) chk("rs_addr", {rs1, rs2}, {r1, r2});
    if (m_out_v) begin
      chk("out_pc", out_pc, m_b.pc);
      chk("out_op1", out_op1, m_b.op1);
      chk("out_op2", out_op2, m_b.op2);
      chk("out_imm", out_imm, m_b.imm);
      chk("out_ctl", {out_rd, out_opcode, out_funct3, out_funct7, out_writes_rd},
          {m_b.rd, m_b.opc, m_b.f3, m_b.f7, m_b.wr});
    end
    n_id_v = m_id_v; n_out_v = m_out_v; n_ins = m_id_ins; n_pc = m_id_pc;
    n_busy = m_busy; nb = m_b;
    if (flush) begin
      n_id_v = 0; n_out_v = 0;
      foreach (n_busy[i]) n_busy[i] = 0;
    end else begin
      if (wb_write && wb_rd != 0) n_busy[wb_rd] = 0;
      if (iss) begin
        nb = '{pc: m_id_pc, op1: regs[r1], op2: regs[r2], imm: f_imm(m_id_ins), rd: rdx,
               opc: op, f7: m_id_ins[31:25], f3: m_id_ins[14:12], wr: wr};
        n_out_v = 1;
        if (wr) n_busy[rdx] = 1;
      end else if (out_ready) begin
        n_out_v = 0;
      end
      if (in_valid && rdy) begin
        n_id_v = 1; n_ins = in_instr; n_pc = in_pc;
      end else if (iss) begin
        n_id_v = 0;
      end
    end
    @(posedge clock);
    m_id_v = n_id_v; m_out_v = n_out_v; m_id_ins = n_ins; m_id_pc = n_pc;
    m_busy = n_busy; m_b = nb;
    #1;
  endtask

  // Reset asserted in the middle of a cycle; state must clear before any clock edge
  task automatic do_reset();
    in_valid = 0; wb_write = 0; flush = 0; out_ready = 1;
    #2 reset = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bundle", {out_rd, out_opcode, out_writes_rd}, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_pc", out_pc, 0);
    m_id_v = 0; m_out_v = 0; m_id_ins = '0; m_id_pc = '0;
    m_b = '{default: '0};
    foreach (m_busy[i]) m_busy[i] = 0;
    @(negedge clock) reset = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [31:0] ins);
    in_valid = 1; in_instr = ins; in_pc = in_pc + 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = T_OP;   1: w[6:0] = T_OPI;  2: w[6:0] = T_LD;
      3: w[6:0] = T_ST;   4: w[6:0] = T_BR;   5: w[6:0] = T_JAL;
      6: w[6:0] = T_JALR; 7: w[6:0] = T_LUI;  default: w[6:0] = T_AUI;
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    do_reset();

    // ADDI x10,x0,5 issues one edge after acceptance
    feed(32'h0050_0513); step();
    in_valid = 0; step();
    chk("t1_valid", out_valid, 1);
    chk("t1_rd", out_rd, 10);
    chk("t1_imm", out_imm, 5);
    chk("t1_op1", out_op1, 0);

    // ADD x11,x10,x10 stalls until x10 is written back, then reads the new value
    feed(32'h00A5_05B3); step();
    in_valid = 0; #1;
    chk("t2_stall_ready", in_ready, 0);
    chk("t2_drop_valid", out_valid, 0);
    step(); step();
    chk("t2_still_stalled", out_valid, 0);
    wb_rd = 10; wb_data = 999; wb_write = 1; #1;
    chk("t2_wb_cycle_ready", in_ready, 0);
    step();
    wb_write = 0;
    chk("t2_no_bypass", out_valid, 0);
    step();
    chk("t2_valid", out_valid, 1);
    chk("t2_op1", out_op1, 999);
    chk("t2_op2", out_op2, 999);
    chk("t2_rd", out_rd, 11);

    // SW x5,-4(x2): no destination, negative S-immediate
    feed(32'hFE51_2E23); step();
    in_valid = 0; step();
    chk("t3_wr", out_writes_rd, 0);
    chk("t3_imm", out_imm, 32'hFFFF_FFFC);
    chk("t3_opc", out_opcode, 7'h23);

    // ADDI x0 then ADD x12,x0,x0 back to back: x0 never stalls
    feed(32'h0010_0013); step();
    feed(32'h0000_0633); #1;
    chk("t3_b2b_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("t3_x0_wr", out_writes_rd, 0);
    step();
    chk("t3_b2b_valid", out_valid, 1);
    chk("t3_b2b_rd", out_rd, 12);
    step();

    // Back-pressure: bundle held stable and second instruction held in the slot
    out_ready = 0;
    feed(32'h0070_0693); step();
    feed(32'h0080_0713); step();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_rd", out_rd, 13);
      chk("t4_hold_imm", out_imm, 7);
      chk("t4_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1; step();
    chk("t4_next_rd", out_rd, 14);

    // Writeback clear and new issue to x7 on the same edge: x7 stays busy
    feed(32'h0010_0393); step();
    feed(32'h0020_0393); step();
    in_valid = 0; wb_rd = 7; wb_data = 55; wb_write = 1;
    step();
    wb_write = 0;
    feed(32'h0003_8433); step();
    in_valid = 0; step();
    chk("t5_stall_valid", out_valid, 0);
    chk("t5_stall_ready", in_ready, 0);
    wb_rd = 7; wb_data = 77; wb_write = 1; step();
    wb_write = 0; step();
    chk("t5_valid", out_valid, 1);
    chk("t5_op1", out_op1, 77);
    chk("t5_rd", out_rd, 8);

    // Flush while stalled on x8 clears the scoreboard
    feed(32'h0004_04B3); step();
    in_valid = 0; step();
    chk("t6_stall_ready", in_ready, 0);
    flush = 1; feed(32'h0010_0093); #1;
    chk("t6_flush_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    chk("t6_flush_valid", out_valid, 0);
    feed(32'h0004_04B3); step();
    in_valid = 0; step();
    chk("t6_post_flush_valid", out_valid, 1);
    chk("t6_post_flush_rd", out_rd, 9);

    // Reset with a bundle valid and a dependent instruction stalled
    feed(32'h0030_0793); step();
    feed(32'h00F7_8833); step();
    in_valid = 0;
    do_reset();
    feed(32'h00F7_8833); step();
    in_valid = 0; step();
    chk("t6_post_rst_valid", out_valid, 1);
    chk("t6_post_rst_rd", out_rd, 16);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        in_valid  = ($urandom_range(0, 9) < 6);
        in_instr  = rand_instr();
        in_pc     = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
        wb_write  = ($urandom_range(0, 9) < 3);
        wb_rd     = 5'($urandom_range(0, 7));
        wb_data   = $urandom;
        flush     = ($urandom_range(0, 49) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
